freq_hist: RTL and testbench

Parametrised symbol-frequency histogram for the Huffman front end: after a Start-triggered clear it counts every valid input symbol into a per-symbol bin. On Last it freezes all bins and raises Done. The Huffman tree builder then reads the counts back through a registered address/data port. This block replaces the fixed ten-symbol, 8-bit, always-enabled counter with configurable width, depth and symbol count, plus input qualification, a framed run and error flags.

---
 rtl/freq_hist_pkg.sv | 11 +
 rtl/freq_hist_bin.sv | 30 +++
 rtl/freq_hist.sv | 107 ++++++++++
 tb/tb_freq_hist.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_hist_pkg.sv
// Shared state encoding and default sizing for the symbol-frequency histogram.
package freq_hist_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, DONE} state_t;

  localparam int DEF_SYM_W   = 4;
  localparam int DEF_NUM_SYM = 10;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TOT_W   = 16;

endpackage

// File: rtl/freq_hist_bin.sv
// One W-bit event counter with clear; count visible the edge after inc, no backpressure.
// ovf flags an increment attempted at all-ones (saturates with FREQ_HIST_SAT_EN, else wraps).
module freq_hist_bin
  import freq_hist_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  assign ovf = inc && (&cnt);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
`ifdef FREQ_HIST_SAT_EN
      if (!ovf) cnt <= cnt + 1'b1;
`else
      cnt <= cnt + 1'b1;
`endif
    end
  end

endmodule

// File: rtl/freq_hist.sv
// Framed symbol histogram (Start -> clear -> count until Last -> Done); bins/Total update 1 cycle after accept,
// Rd_cnt 1-cycle readout; one symbol per cycle, no backpressure. FREQ_HIST_SAT_EN selects saturating counters.
module freq_hist
  import freq_hist_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int NUM_SYM = DEF_NUM_SYM,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TOT_W   = DEF_TOT_W
) (
  input  logic                       Clk_in,
  input  logic                       Rst,
  input  logic                       Start,
  input  logic                       Din_valid,
  input  logic [SYM_W-1:0]           Data_in,
  input  logic                       Last,
  output logic                       Busy,
  output logic                       Done,
  input  logic [$clog2(NUM_SYM)-1:0] Rd_addr,
  output logic [CNT_W-1:0]           Rd_cnt,
  output logic [TOT_W-1:0]           Total,
  output logic                       Bad_sym,
  output logic                       Ovf
);

  localparam int AW = $clog2(NUM_SYM);

  state_t             state;
  logic [AW-1:0]      clr_idx;
  logic [CNT_W-1:0]   bin_cnt [NUM_SYM];
  logic [NUM_SYM-1:0] bin_ovf;
  logic               tot_ovf;
  logic               in_range;
  logic               accept;
  logic               first_clr;

  assign in_range  = int'(Data_in) < NUM_SYM;
  // A Start in COUNT wins over the symbol presented in the same cycle.
  assign accept    = (state == COUNT) && !Start && Din_valid;
  assign first_clr = (state == CLEAR) && (clr_idx == '0);

  for (genvar i = 0; i < NUM_SYM; i++) begin : g_bin
    freq_hist_bin #(.W(CNT_W)) u_bin (
      .clk (Clk_in),
      .rst (Rst),
      .clr ((state == CLEAR) && (clr_idx == AW'(i))),
      .inc (accept && (Data_in == SYM_W'(i))),
      .cnt (bin_cnt[i]),
      .ovf (bin_ovf[i])
    );
  end

  freq_hist_bin #(.W(TOT_W)) u_total (
    .clk (Clk_in),
    .rst (Rst),
    .clr (first_clr),
    .inc (accept && in_range),
    .cnt (Total),
    .ovf (tot_ovf)
  );

  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      state   <= IDLE;
      clr_idx <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Bad_sym <= 1'b0;
      Ovf     <= 1'b0;
    end else if (Start) begin
      state   <= CLEAR;
      clr_idx <= '0;
      Busy    <= 1'b1;
      Done    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == '0) begin
            Bad_sym <= 1'b0;
            Ovf     <= 1'b0;
          end
          if (clr_idx == AW'(NUM_SYM - 1)) state <= COUNT;
          else clr_idx <= clr_idx + 1'b1;
        end
        COUNT: begin
          if (Din_valid) begin
            if (!in_range) Bad_sym <= 1'b1;
            if ((|bin_ovf) || tot_ovf) Ovf <= 1'b1;
            if (Last) begin
              state <= DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Rst) Rd_cnt <= '0;
    else if (int'(Rd_addr) < NUM_SYM) Rd_cnt <= bin_cnt[Rd_addr];
    else Rd_cnt <= '0;
  end

endmodule

// File: tb/tb_freq_hist.sv
// Self-checking bench for freq_hist: vector table, corner sequences and random runs against a counting model.
`timescale 1ns/1ps
module tb_freq_hist;

  localparam int SYM_W   = 4;
  localparam int NUM_SYM = 10;
  localparam int CNT_W   = 4;
  localparam int TOT_W   = 16;
  localparam int AW      = $clog2(NUM_SYM);
`ifdef FREQ_HIST_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             Clk_in = 1'b0;
  logic             Rst, Start, Din_valid, Last;
  logic [SYM_W-1:0] Data_in;
  logic [AW-1:0]    Rd_addr;
  logic             Busy, Done, Bad_sym, Ovf;
  logic [CNT_W-1:0] Rd_cnt;
  logic [TOT_W-1:0] Total;

  int n_cmp = 0;
  int n_err = 0;

  int m_bin [NUM_SYM];
  int m_tot;
  bit m_bad, m_ovf;

  typedef struct {
    bit start;
    bit vld;
    int sym;
    bit last;
    int exp_tot;
    bit exp_bad;
    bit exp_done;
  } vec_t;

  vec_t tbl [16];

  always #5 Clk_in = ~Clk_in;

  freq_hist #(.SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .Clk_in   (Clk_in),
    .Rst      (Rst),
    .Start    (Start),
    .Din_valid(Din_valid),
    .Data_in  (Data_in),
    .Last     (Last),
    .Busy     (Busy),
    .Done     (Done),
    .Rd_addr  (Rd_addr),
    .Rd_cnt   (Rd_cnt),
    .Total    (Total),
    .Bad_sym  (Bad_sym),
    .Ovf      (Ovf)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk_in);
    #1;
  endtask

  function automatic void model_clear;
    for (int i = 0; i < NUM_SYM; i++) m_bin[i] = 0;
    m_tot = 0;
    m_bad = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_accept(input int sym);
    int bmax, tmax;
    bmax = (1 << CNT_W) - 1;
    tmax = (1 << TOT_W) - 1;
    if (sym >= NUM_SYM) begin
      m_bad = 1;
      return;
    end
    if (m_bin[sym] == bmax) begin
      m_ovf = 1;
      m_bin[sym] = SAT ? bmax : 0;
    end else begin
      m_bin[sym]++;
    end
    if (m_tot == tmax) begin
      m_ovf = 1;
      m_tot = SAT ? tmax : 0;
    end else begin
      m_tot++;
    end
  endfunction

  task automatic do_start(input string tag);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    check({tag, "_busy_after_start"}, Busy, 1);
    check({tag, "_done_after_start"}, Done, 0);
    repeat (NUM_SYM) tick;
    model_clear();
    check({tag, "_total_cleared"}, Total, 0);
  endtask

  task automatic send(input int sym, input bit vld, input bit lst);
    Data_in   = SYM_W'(sym);
    Din_valid = vld;
    Last      = lst;
    tick;
    Din_valid = 1'b0;
    Last      = 1'b0;
    if (vld) model_accept(sym);
  endtask

  task automatic check_bins(input string tag);
    for (int a = 0; a < (1 << AW); a++) begin
      Rd_addr = AW'(a);
      tick;
      check($sformatf("%s_bin%0d", tag, a), Rd_cnt, (a < NUM_SYM) ? m_bin[a] : 0);
    end
  endtask

  function automatic vec_t mk(input bit st, input bit v, input int s, input bit l,
                              input int t, input bit b, input bit d);
    vec_t r;
    r.start = st; r.vld = v; r.sym = s; r.last = l;
    r.exp_tot = t; r.exp_bad = b; r.exp_done = d;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit busy_ok;
    Rst = 1'b1; Start = 1'b0; Din_valid = 1'b0; Last = 1'b0;
    Data_in = '0; Rd_addr = '0;
    model_clear();
    repeat (3) tick;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_total", Total, 0);
    check("rst_bad", Bad_sym, 0);
    check("rst_ovf", Ovf, 0);
    check("rst_rdcnt", Rd_cnt, 0);
    Rst = 1'b0;
    check_bins("rst");

    // Run 1: reference mix; run 2: out-of-range symbol and an idle cycle.
    tbl[0]  = mk(1, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8,  0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 9,  0, 2, 0, 0);
    tbl[3]  = mk(0, 1, 9,  0, 3, 0, 0);
    tbl[4]  = mk(0, 1, 7,  0, 4, 0, 0);
    tbl[5]  = mk(0, 1, 6,  0, 5, 0, 0);
    tbl[6]  = mk(0, 1, 6,  0, 6, 0, 0);
    tbl[7]  = mk(0, 1, 5,  0, 7, 0, 0);
    tbl[8]  = mk(0, 1, 5,  0, 8, 0, 0);
    tbl[9]  = mk(0, 1, 5,  1, 9, 0, 1);
    tbl[10] = mk(1, 0, 0,  0, 0, 0, 0);
    tbl[11] = mk(0, 1, 3,  0, 1, 0, 0);
    tbl[12] = mk(0, 0, 3,  0, 1, 0, 0);
    tbl[13] = mk(0, 1, 12, 0, 1, 1, 0);
    tbl[14] = mk(0, 1, 0,  0, 2, 1, 0);
    tbl[15] = mk(0, 1, 15, 1, 2, 1, 1);

    for (int r = 0; r < 16; r++) begin
      if (tbl[r].start) begin
        do_start($sformatf("vec%0d", r));
      end else begin
        send(tbl[r].sym, tbl[r].vld, tbl[r].last);
        check($sformatf("vec%0d_total", r), Total, tbl[r].exp_tot);
        check($sformatf("vec%0d_bad", r), Bad_sym, tbl[r].exp_bad);
        check($sformatf("vec%0d_done", r), Done, tbl[r].exp_done);
        check($sformatf("vec%0d_busy", r), Busy, !tbl[r].exp_done);
        if (tbl[r].last) check_bins($sformatf("vec%0d", r));
      end
    end

    // Counter limit: Ovf only once an increment goes past all-ones.
    do_start("sat");
    for (int i = 0; i < 17; i++) begin
      send(3, 1, i == 16);
      if (i == 14) check("sat_ovf_at_max", Ovf, 0);
      if (i == 15) check("sat_ovf_past_max", Ovf, 1);
    end
    Rd_addr = AW'(3);
    tick;
    check("sat_bin3", Rd_cnt, SAT ? 15 : 1);
    check("sat_ovf", Ovf, 1);
    check("sat_total", Total, 17);
    check_bins("sat");

    // Restart in the middle of COUNT.
    do_start("rs");
    for (int i = 0; i < 5; i++) send(2, 1, 0);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    busy_ok = Busy;
    for (int i = 0; i < NUM_SYM; i++) begin
      tick;
      busy_ok = busy_ok && Busy;
    end
    check("rs_busy_held", busy_ok, 1);
    model_clear();
    check("rs_total_zero", Total, 0);
    check_bins("rs_cleared");
    send(2, 1, 0);
    send(2, 1, 1);
    check("rs_total", Total, 2);
    check("rs_done", Done, 1);
    check_bins("rs_new");

    // Din_valid held through CLEAR: ignored for exactly NUM_SYM cycles, then counted.
    Start = 1'b1; Din_valid = 1'b1; Data_in = SYM_W'(2); Last = 1'b0;
    tick;
    Start = 1'b0;
    repeat (NUM_SYM) tick;
    model_clear();
    check("clr_hold_total_at_count", Total, 0);
    tick;
    Din_valid = 1'b0;
    model_accept(2);
    check("clr_hold_total", Total, 1);
    check_bins("clr_hold");

    // Reset in the middle of COUNT.
    send(4, 1, 0);
    send(7, 1, 0);
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    model_clear();
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_total", Total, 0);
    check("midrst_rdcnt", Rd_cnt, 0);
    Data_in = SYM_W'(4); Din_valid = 1'b1; Last = 1'b1;
    tick;
    Din_valid = 1'b0; Last = 1'b0;
    check("idle_ignores_total", Total, 0);
    check("idle_ignores_done", Done, 0);
    check_bins("midrst");

    // Random runs against the model.
    for (int run = 0; run < 3; run++) begin
      int len;
      do_start($sformatf("rnd%0d", run));
      len = $urandom_range(20, 60);
      for (int i = 0; i < len; i++) begin
        bit v;
        v = ($urandom_range(0, 3) != 0) || (i == len - 1);
        send($urandom_range(0, 15), v, i == len - 1);
      end
      check($sformatf("rnd%0d_done", run), Done, 1);
      check($sformatf("rnd%0d_total", run), Total, m_tot);
      check($sformatf("rnd%0d_bad", run), Bad_sym, m_bad);
      check($sformatf("rnd%0d_ovf", run), Ovf, m_ovf);
      check_bins($sformatf("rnd%0d", run));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
